// File: rtl/can_rx_drain.sv
// can_rx_drain: drains received CAN frames from a PVCI-attached controller into a 32-byte FWFT FIFO
module can_rx_drain (
    input  logic       hclk,
    input  logic       hresetn,
    input  logic       enable,
    input  logic       nint,
    output logic [7:0] pvci_addr,
    output logic [7:0] pvci_wdata,
    output logic       pvci_valid,
    output logic       pvci_read,
    input  logic [7:0] pvci_rdata,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic [5:0] level,
    output logic [7:0] frames_rx,
    output logic       busy
);
    typedef enum logic [2:0] {
        IDLE, STAT_RD, STAT_CHK, INFO_RD, INFO_CHK, BYTE_RD, BYTE_PUSH, RELEASE
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] ptr;
    logic [3:0] remaining;
    logic [7:0] mem [32];
    logic [4:0] wr_ptr, rd_ptr;
    logic       push, pop_ok;
    logic [3:0] dlc, total;

    // frame length from the info byte: header (3 std / 5 ext) plus clamped DLC unless RTR
    assign dlc    = pvci_rdata[3:0] > 4'd8 ? 4'd8 : pvci_rdata[3:0];
    assign total  = (pvci_rdata[7] ? 4'd5 : 4'd3) + (pvci_rdata[6] ? 4'd0 : dlc);
    assign push   = state == INFO_CHK || state == BYTE_PUSH;
    assign pop_ok = pop && !empty;
    assign empty  = level == 6'd0;
    assign dout   = empty ? 8'h00 : mem[rd_ptr];
    assign busy   = state != IDLE;

    // state register
    always_ff @(posedge hclk or negedge hresetn)
        if (!hresetn) state <= IDLE;
        else          state <= state_nxt;

    // next-state: a frame is only started when a worst-case 13-byte frame still fits
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = (enable && !nint && level <= 6'd19) ? STAT_RD : IDLE;
            STAT_RD:   state_nxt = STAT_CHK;
            STAT_CHK:  state_nxt = pvci_rdata[0] ? INFO_RD : IDLE;
            INFO_RD:   state_nxt = INFO_CHK;
            INFO_CHK:  state_nxt = BYTE_RD;
            BYTE_RD:   state_nxt = BYTE_PUSH;
            BYTE_PUSH: state_nxt = remaining == 4'd1 ? RELEASE : BYTE_RD;
            RELEASE:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // PVCI request outputs; bus fields are zero whenever no request is presented
    always_comb begin
        pvci_valid = 1'b0;
        pvci_read  = 1'b0;
        pvci_addr  = 8'h00;
        pvci_wdata = 8'h00;
        case (state)
            STAT_RD: begin pvci_valid = 1'b1; pvci_read = 1'b1; pvci_addr = 8'h02; end
            INFO_RD: begin pvci_valid = 1'b1; pvci_read = 1'b1; pvci_addr = 8'h10; end
            BYTE_RD: begin pvci_valid = 1'b1; pvci_read = 1'b1; pvci_addr = ptr; end
            RELEASE: begin pvci_valid = 1'b1; pvci_addr = 8'h01; pvci_wdata = 8'h04; end
            default: ;
        endcase
    end

    // byte pointer, remaining-byte count and received-frame counter
    always_ff @(posedge hclk or negedge hresetn)
        if (!hresetn) begin
            ptr       <= 8'h00;
            remaining <= 4'd0;
            frames_rx <= 8'h00;
        end else begin
            if (state == INFO_CHK) begin
                ptr       <= 8'h11;
                remaining <= total - 4'd1;
            end else if (state == BYTE_PUSH) begin
                ptr       <= ptr + 8'd1;
                remaining <= remaining - 4'd1;
            end
            if (state == RELEASE) frames_rx <= frames_rx + 8'd1;
        end

    // FIFO pointers and occupancy; simultaneous push and pop leaves level unchanged
    always_ff @(posedge hclk or negedge hresetn)
        if (!hresetn) begin
            wr_ptr <= 5'd0;
            rd_ptr <= 5'd0;
            level  <= 6'd0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 5'd1;
            if (pop_ok) rd_ptr <= rd_ptr + 5'd1;
            level <= level + {5'd0, push} - {5'd0, pop_ok};
        end

    // FIFO storage; contents need no reset since dout is masked while empty
    always_ff @(posedge hclk)
        if (push) mem[wr_ptr] <= pvci_rdata;
endmodule

// File: tb/tb_can_rx_drain.sv
// tb_can_rx_drain: scoreboard bench with a behavioural CAN controller and FIFO consumer
module tb_can_rx_drain;
    logic       hclk = 0, hresetn = 1, enable = 1, nint = 1, pop = 0;
    logic [7:0] pvci_rdata = 0;
    logic [7:0] pvci_addr, pvci_wdata, dout, frames_rx;
    logic       pvci_valid, pvci_read, empty, busy;
    logic [5:0] level;

    logic [7:0] regs [256];
    logic [7:0] exp_q [$];
    int         vectors = 0, miscompares = 0;
    int         releases = 0, stat_reads = 0, data_reads = 0, valid_cnt = 0, lvl_m = 0;
    logic [7:0] frames_exp = 0, last_addr = 0;
    logic       pop_en = 0, force_pop = 0, chk_frames = 0, last_rd = 0, push_now = 0;

    can_rx_drain dut (
        .hclk(hclk), .hresetn(hresetn), .enable(enable), .nint(nint),
        .pvci_addr(pvci_addr), .pvci_wdata(pvci_wdata), .pvci_valid(pvci_valid),
        .pvci_read(pvci_read), .pvci_rdata(pvci_rdata), .pop(pop), .dout(dout),
        .empty(empty), .level(level), .frames_rx(frames_rx), .busy(busy)
    );

    always #5 hclk = ~hclk;

    task automatic check(string name, int act, int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge hclk);
        #1;
    endtask

    // place a frame in the controller and queue the bytes the FIFO must deliver
    task automatic load_frame(logic [7:0] info);
        int n;
        n = (info[7] ? 5 : 3) + (info[6] ? 0 : (info[3:0] > 8 ? 8 : int'(info[3:0])));
        regs[8'h10] = info;
        for (int i = 1; i < 13; i++) regs[8'h10 + i] = 8'($urandom);
        for (int i = 0; i < n; i++) exp_q.push_back(regs[8'h10 + i]);
        regs[2] = 8'($urandom) | 8'h01;
        nint = 0;
    endtask

    task automatic wait_release(int bound);
        int r0, n;
        r0 = releases;
        n = 0;
        while (releases == r0 && n < bound) begin tick(1); n++; end
        check("release_count", releases - r0, 1);
    endtask

    task automatic drain();
        int n;
        pop_en = 1;
        n = 0;
        while ((!empty || exp_q.size() != 0) && n < 1000) begin tick(1); n++; end
        pop_en = 0;
        tick(2);
        check("drain_level", level, 0);
        check("drain_queue", exp_q.size(), 0);
    endtask

    // controller model, consumer and scoreboard monitor, all sampled on the falling edge
    always @(negedge hclk) begin
        check("level", level, lvl_m);
        check("empty", empty, lvl_m == 0);
        if (chk_frames) begin
            chk_frames = 0;
            check("frames_rx", frames_rx, frames_exp);
        end
        push_now = 0;
        if (pvci_valid) begin
            valid_cnt++;
            if (pvci_read) begin
                pvci_rdata = regs[pvci_addr];
                if (pvci_addr == 8'h02) stat_reads++;
                else data_reads++;
            end else begin
                check("release_addr", pvci_addr, 8'h01);
                check("release_wdata", pvci_wdata, 8'h04);
                releases++;
                frames_exp++;
                chk_frames = 1;
                regs[2] = 8'h00;
                nint = 1;
            end
            last_rd = pvci_read;
            last_addr = pvci_addr;
        end else begin
            check("idle_bus", {pvci_addr, pvci_wdata, pvci_read}, 0);
            push_now = last_rd && last_addr != 8'h02;
            if (!last_rd) pvci_rdata = 8'($urandom);
            last_rd = 0;
        end
        pop = hresetn && (pop_en ? ($urandom_range(0, 3) == 0) : force_pop);
        if (empty) check("dout_empty", dout, 0);
        else if (pop) begin
            if (exp_q.size() == 0) check("unexpected_byte", exp_q.size(), 1);
            else check("dout", dout, exp_q.pop_front());
        end
        lvl_m = lvl_m + int'(push_now) - int'(pop && !empty);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s0, d0, v0, r0, n;
        logic [7:0] info;
        for (int i = 0; i < 256; i++) regs[i] = 8'($urandom);
        #2 hresetn = 0;
        tick(2);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_dout", dout, 0);
        check("rst_frames", frames_rx, 0);
        check("rst_busy", busy, 0);
        check("rst_bus", {pvci_valid, pvci_read, pvci_addr, pvci_wdata}, 0);
        hresetn = 1;
        tick(2);

        // status 0x00 with interrupt pending: status-only polling every third cycle
        regs[2] = 8'h00;
        s0 = stat_reads; d0 = data_reads;
        nint = 0;
        tick(9);
        nint = 1;
        tick(3);
        check("poll_stat_reads", stat_reads - s0, 3);
        check("poll_frame_reads", data_reads - d0, 0);
        check("poll_busy", busy, 0);

        // standard 8-byte frame
        d0 = data_reads;
        load_frame(8'h08);
        wait_release(60);
        tick(2);
        check("std_level", level, 11);
        check("std_frame_reads", data_reads - d0, 11);
        check("std_frames_rx", frames_rx, 1);
        drain();

        // extended remote frame: header only
        d0 = data_reads;
        load_frame(8'hC5);
        wait_release(60);
        tick(2);
        check("rtr_level", level, 5);
        check("rtr_frame_reads", data_reads - d0, 5);
        drain();

        // DLC above 8 is clamped, info byte preserved
        load_frame(8'h0F);
        wait_release(60);
        tick(2);
        check("dlc15_level", level, 11);
        drain();

        // backpressure at level 20, released by a single pop
        load_frame(8'h08);
        wait_release(60);
        load_frame(8'h06);
        wait_release(60);
        tick(2);
        check("bp_level", level, 20);
        load_frame(8'h08);
        v0 = valid_cnt;
        tick(20);
        check("bp_no_access", valid_cnt - v0, 0);
        check("bp_busy", busy, 0);
        force_pop = 1;
        tick(1);
        force_pop = 0;
        wait_release(60);
        tick(2);
        check("bp_level_after", level, 30);
        drain();

        // enable dropped mid-frame: frame completes, then engine stays idle
        load_frame(8'h08);
        n = 0;
        while (!busy && n < 20) begin tick(1); n++; end
        check("en_busy_seen", busy, 1);
        tick(4);
        enable = 0;
        wait_release(60);
        tick(2);
        check("en_level", level, 11);
        load_frame(8'h03);
        v0 = valid_cnt;
        tick(20);
        check("en_no_access", valid_cnt - v0, 0);
        check("en_busy", busy, 0);
        enable = 1;
        wait_release(60);
        tick(2);
        check("en_level_after", level, 17);
        drain();

        // pop while empty is ignored
        force_pop = 1;
        tick(4);
        force_pop = 0;
        tick(1);
        check("pop_empty_level", level, 0);
        check("pop_empty_flag", empty, 1);

        // reset during byte transfer discards the partial frame, no release
        load_frame(8'h88);
        r0 = releases; d0 = data_reads; n = 0;
        while (data_reads - d0 < 3 && n < 100) begin tick(1); n++; end
        check("rst_reach_bytes", data_reads - d0, 3);
        tick(1);
        hresetn = 0;
        nint = 1;
        regs[2] = 8'h00;
        exp_q.delete();
        frames_exp = 0;
        lvl_m = 0;
        #1;
        check("mid_rst_level", level, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_dout", dout, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_frames", frames_rx, 0);
        tick(2);
        hresetn = 1;
        tick(5);
        check("mid_rst_no_release", releases - r0, 0);
        check("mid_rst_level_after", level, 0);

        // randomized frames with a slow random consumer (exercises push+pop and backpressure)
        pop_en = 1;
        repeat (40) begin
            info = 8'($urandom);
            load_frame(info);
            wait_release(400);
        end
        drain();
        check("final_frames", frames_rx, frames_exp);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
